// File: rtl/ayumu_pkg.sv
// ayumu_pkg: shared ALU op encodings, stage state and width defaults
package ayumu_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam logic [1:0] MODE_ALU  = 2'b00;
  localparam logic [1:0] MODE_CMP  = 2'b01;
  localparam logic [1:0] MODE_MOV0 = 2'b10;
  localparam logic [1:0] MODE_MOV1 = 2'b11;
  localparam logic [3:0] CAL_ADD = 4'b0000;
  localparam logic [3:0] CAL_ADC = 4'b0001;
  localparam logic [3:0] CAL_SUB = 4'b0010;
  localparam logic [3:0] CAL_SBB = 4'b0011;
  localparam logic [3:0] CAL_AND = 4'b0100;
  localparam logic [3:0] CAL_OR  = 4'b0101;
  localparam logic [3:0] CAL_XOR = 4'b0110;
  localparam logic [3:0] CAL_SHL = 4'b0111;
  localparam logic [3:0] CAL_SHR = 4'b1000;
  localparam logic [3:0] CAL_ROL = 4'b1001;
  localparam logic [3:0] CAL_ROR = 4'b1010;
  localparam logic [3:0] CAL_NOT = 4'b1011;
  localparam logic [3:0] CMP_EQ = 4'b0000;
  localparam logic [3:0] CMP_NE = 4'b0001;
  localparam logic [3:0] CMP_LT = 4'b0010;
  localparam logic [3:0] CMP_GT = 4'b0011;
  localparam logic [3:0] CMP_LE = 4'b0100;
  localparam logic [3:0] CMP_GE = 4'b0101;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} wb_state_t;
  function automatic logic cal_defined(input logic [3:0] cal);
    return cal <= CAL_NOT;
  endfunction
  // compares never write back, whatever the WE bit says
  function automatic logic op_writes(input logic [1:0] mode, input logic we);
    return we && mode != MODE_CMP;
  endfunction
endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if: issue, ALU result, writeback and flag signals of the writeback stage
interface alu_writeback_if #(
  parameter int DATA_W = ayumu_pkg::DEFAULT_DATA_W,
  parameter int ADDR_W = ayumu_pkg::DEFAULT_ADDR_W
);
  logic              ISSUE_VALID;
  logic              ISSUE_READY;
  logic [1:0]        ISSUE_MODE;
  logic [3:0]        ISSUE_CAL;
  logic [ADDR_W-1:0] ISSUE_DST;
  logic              ISSUE_WE;
  logic [DATA_W-1:0] ALU_OUT;
  logic              ALU_C_OUT;
  logic              ALU_F_OUT;
  logic              WB_VALID;
  logic              WB_READY;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic              C_FLAG;
  logic              F_FLAG;
  logic              BUSY;
  modport master (
    output ISSUE_VALID, ISSUE_MODE, ISSUE_CAL, ISSUE_DST, ISSUE_WE,
    output ALU_OUT, ALU_C_OUT, ALU_F_OUT, WB_READY,
    input  ISSUE_READY, WB_VALID, WB_ADDR, WB_DATA, C_FLAG, F_FLAG, BUSY
  );
  modport slave (
    input  ISSUE_VALID, ISSUE_MODE, ISSUE_CAL, ISSUE_DST, ISSUE_WE,
    input  ALU_OUT, ALU_C_OUT, ALU_F_OUT, WB_READY,
    output ISSUE_READY, WB_VALID, WB_ADDR, WB_DATA, C_FLAG, F_FLAG, BUSY
  );
endinterface

// File: rtl/alu_flag_reg.sv
// alu_flag_reg: architectural carry/compare flags updated from ALU outputs by MODE/CAL
module alu_flag_reg
  import ayumu_pkg::*;
(
  input  logic       CLK_EX,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [3:0] cal,
  input  logic       c_out,
  input  logic       f_out,
  output logic       c_flag,
  output logic       f_flag
);
  logic c_nxt, f_nxt;
  // undefined arithmetic CALs clear carry rather than keep a stale value
  always_comb begin
    c_nxt = mode == MODE_ALU ? cal_defined(cal) & c_out : c_flag;
    f_nxt = mode == MODE_CMP ? f_out : f_flag;
  end
  always_ff @(posedge CLK_EX or posedge RST)
    if (RST) begin
      c_flag <= 1'b0;
      f_flag <= 1'b0;
    end else if (en) begin
      c_flag <= c_nxt;
      f_flag <= f_nxt;
    end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: captures ALU results one cycle after issue, owns flags, drives register-file writes
module alu_writeback
  import ayumu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic            CLK_EX,
  input logic            RST,
  alu_writeback_if.slave bus
);
  wb_state_t         state, state_nxt;
  logic [1:0]        mode_q;
  logic [3:0]        cal_q;
  logic [ADDR_W-1:0] dst_q;
  logic              we_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              issue_ready, issue_fire, wb_fire, capture, wr;
  // issue is blocked through EXEC so the next op always sees updated flags
  assign issue_ready = state == IDLE || (state == HOLD && bus.WB_READY);
  assign issue_fire  = bus.ISSUE_VALID && issue_ready;
  assign wb_fire     = wb_valid_q && bus.WB_READY;
  assign capture     = state == EXEC;
  assign wr          = op_writes(mode_q, we_q);
  always_ff @(posedge CLK_EX or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (issue_fire ? EXEC : IDLE) :
                state == EXEC ? (wr ? HOLD : IDLE) :
                state == HOLD ? (wb_fire ? (issue_fire ? EXEC : IDLE) : HOLD) : IDLE;
  end
  always_ff @(posedge CLK_EX or posedge RST)
    if (RST) begin
      mode_q <= MODE_ALU;
      cal_q  <= CAL_ADD;
      dst_q  <= '0;
      we_q   <= 1'b0;
    end else if (issue_fire) begin
      mode_q <= bus.ISSUE_MODE;
      cal_q  <= bus.ISSUE_CAL;
      dst_q  <= bus.ISSUE_DST;
      we_q   <= bus.ISSUE_WE;
    end
  always_ff @(posedge CLK_EX or posedge RST)
    if (RST) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else if (capture && wr) begin
      wb_valid_q <= 1'b1;
      wb_addr_q  <= dst_q;
      wb_data_q  <= bus.ALU_OUT;
    end else if (wb_fire) begin
      wb_valid_q <= 1'b0;
    end
  alu_flag_reg u_flags (
    .CLK_EX (CLK_EX),
    .RST    (RST),
    .en     (capture),
    .mode   (mode_q),
    .cal    (cal_q),
    .c_out  (bus.ALU_C_OUT),
    .f_out  (bus.ALU_F_OUT),
    .c_flag (bus.C_FLAG),
    .f_flag (bus.F_FLAG)
  );
  assign bus.ISSUE_READY = issue_ready;
  assign bus.WB_VALID    = wb_valid_q;
  assign bus.WB_ADDR     = wb_addr_q;
  assign bus.WB_DATA     = wb_data_q;
  assign bus.BUSY        = state != IDLE;
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-writeback stage directly downstream of the 8-bit ALU.
- Tracks each op issued to the ALU and captures ALU OUT/C_OUT/F_OUT one cycle after issue.
- Owns the architectural carry and compare flags, which feed back to the ALU C_IN/F_IN.
- Presents register-file writes with a valid/ready handshake; gates issue so flags are never read stale.

Parameters:
- DATA_W, 8, ALU result / register width.
- ADDR_W, 3, destination register address width (8 registers).

Ports:
- CLK_EX  in  1  execute clock; the same edge on which the ALU samples its operands.
- RST  in  1  asynchronous, active-high reset.
- ISSUE_VALID  in  1  op is presented to the ALU this cycle.
- ISSUE_READY  out  1  stage can accept an issue; fire = ISSUE_VALID & ISSUE_READY.
- ISSUE_MODE  in  2  ALU MODE of the issued op.
- ISSUE_CAL  in  4  ALU CAL of the issued op.
- ISSUE_DST  in  ADDR_W  destination register.
- ISSUE_WE  in  1  op writes its result to ISSUE_DST.
- ALU_OUT  in  DATA_W  ALU OUT.
- ALU_C_OUT  in  1  ALU C_OUT.
- ALU_F_OUT  in  1  ALU F_OUT.
- WB_VALID  out  1  writeback pending.
- WB_READY  in  1  register file accepts the write; wb fire = WB_VALID & WB_READY.
- WB_ADDR  out  ADDR_W  write address.
- WB_DATA  out  DATA_W  write data.
- C_FLAG  out  1  carry flag; drives ALU C_IN.
- F_FLAG  out  1  compare flag; drives ALU F_IN.
- BUSY  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, CLK_EX. RST is asynchronous and active-high.
- Reset values: state=IDLE, WB_VALID=0, WB_ADDR=0, WB_DATA=0, C_FLAG=0, F_FLAG=0, BUSY=0, ISSUE_READY=1.
- Reset mid-operation: an in-flight op or pending write is discarded; no write is emitted after reset.
- States: IDLE, EXEC, HOLD.

Issue and capture:
- Issue fire at edge k: the ALU samples the op at edge k. The stage latches MODE/CAL/DST/WE into meta registers and enters EXEC.
- EXEC (exactly 1 cycle): ALU outputs reflect the op. At edge k+1 the stage captures them and applies the flag rules below.
- After capture: if the op writes (see below), set WB_VALID=1 with WB_ADDR=DST and WB_DATA=ALU_OUT, and go to HOLD; otherwise go to IDLE.

Flag rules (applied at the capture edge):
- MODE 00 with CAL 0000..1011: C_FLAG <= ALU_C_OUT. Undefined CAL: C_FLAG <= 0.
- MODE 01: F_FLAG <= ALU_F_OUT.
- MODE 10/11: flags unchanged.

Write rules:
- Writes occur only when WE=1 and MODE != 01.
- Compares never write, regardless of WE.

HOLD and issue gating:
- HOLD: WB outputs are stable until wb fire. On wb fire, WB_VALID drops the next edge; go to IDLE, or to EXEC if an issue fires on the same edge.
- ISSUE_READY = (state==IDLE) | (state==HOLD & WB_READY). It is 0 throughout EXEC.
- Throughput: at most 1 op per 2 cycles, and the next op's C_IN/F_IN always reflect the previous op.
- Simultaneous wb fire and issue fire in HOLD: both take effect; new meta is latched, and WB_VALID=0 during the new EXEC.
- Latency: issue edge to WB_VALID high is 1 edge. WB_VALID may stay high indefinitely while WB_READY=0; flags are already updated at capture.
- Arithmetic: WB_DATA is exactly ALU_OUT with no re-extension. C_FLAG is bit 8 of the ALU result as provided.

Decomposition:
- Shared package `ayumu_pkg`:
  - MODE constants: MODE_ALU=00, MODE_CMP=01, MODE_MOV0=10, MODE_MOV1=11.
  - CAL constants: ADD..NOT = 0000..1011, EQ..GE = 0000..0101.
  - Stage state enum: IDLE/EXEC/HOLD.
  - DATA_W/ADDR_W defaults.
- One natural sub-module, `alu_flag_reg`, holds C_FLAG/F_FLAG with the MODE/CAL update rules, so the decoder stage can reuse it.

Test Plan:
- Reset then issue MODE 00 CAL 0000 with A=0xF0, B=0x20, DST=3, WE=1 -> WB_VALID at the next edge, WB_ADDR=3, WB_DATA=0x10, C_FLAG=1.
- Issue MODE 01 CAL 0010 with A=5, B=9, WE=1 -> F_FLAG=1, WB_VALID never asserts, state returns to IDLE after 1 EXEC cycle.
- Hold WB_READY=0 for 4 cycles after an ADD 0x01+0x01 to DST=7 -> WB_DATA=0x02 and WB_ADDR=7 stable, ISSUE_READY=0. Raise WB_READY together with ISSUE_VALID (MOV) -> write accepted and new op enters EXEC on the same edge.
- ADD 0xFF+0x01 (C_FLAG=1), then ADC 0x00+0x00 -> second WB_DATA=0x01. ISSUE_READY is low during the first EXEC, so C_IN is never stale.
- Assert RST during EXEC of ADD to DST=2 -> WB_VALID=0, C_FLAG=0, F_FLAG=0, state IDLE; no write is ever emitted for that op.
- MODE 10 with A=0x5A, WE=1, DST=1 -> WB_DATA=0x5A; C_FLAG and F_FLAG retain their prior values (set to 1/1 beforehand).
